// File: rtl/sub_pkg.sv
// Shared definitions for the registered ripple-borrow subtractor and its
// golden reference model.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Reference difference {0,a}-{0,b}, truncated to w+1 bits (w <= 32)
  function automatic logic [32:0] ref_sub(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] full;
    logic [32:0] mask;
    full = {1'b0, a} - {1'b0, b};
    mask = (33'd1 << (w + 1)) - 33'd1;
    return full & mask;
  endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_4bit.sv
// Registered unsigned subtractor: ripple-borrow chain of full_sub cells feeding
// a single output register stage carrying diff, borrow, zero and valid.
module sub_4bit
  import sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   diff,
  output logic             borrow,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH:0]   bchain_p0;
  logic [WIDTH-1:0] d_p0;
  logic [WIDTH:0]   diff_p0;
  logic             zero_p0;

  logic [WIDTH:0]   diff_p1;
  logic             zero_p1;
  logic             vld_p1;

  assign bchain_p0[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_sub u_full_sub (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (bchain_p0[i]),
      .d    (d_p0[i]),
      .bout (bchain_p0[i+1])
    );
  end

  // Final borrow out becomes the sign bit; zero reuses the chain's result
  assign diff_p0 = {bchain_p0[WIDTH], d_p0};
  assign zero_p0 = ~|diff_p0;

  // Stage p0 -> p1: output register; data holds when no new sample arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_p1 <= '0;
      zero_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        diff_p1 <= diff_p0;
        zero_p1 <= zero_p0;
      end
    end
  end

  assign diff      = diff_p1;
  assign borrow    = diff_p1[WIDTH];
  assign zero      = zero_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_sub_4bit.sv
// Directed and exhaustive checks of sub_4bit at WIDTH=4, plus random WIDTH=8.
module tb_sub_4bit;
  import sub_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a, b;
  logic [4:0] diff;
  logic       borrow, zero, out_valid;

  logic [7:0] a8, b8;
  logic [8:0] diff8;
  logic       borrow8, zero8, out_valid8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sub_4bit #(.WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .diff(diff), .borrow(borrow), .zero(zero), .out_valid(out_valid)
  );

  sub_4bit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8),
    .diff(diff8), .borrow(borrow8), .zero(zero8), .out_valid(out_valid8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int exp_diff, input bit exp_borrow,
                         input bit exp_zero, input bit exp_vld);
    chk({tag, ".diff"},   32'(diff),      32'(exp_diff));
    chk({tag, ".borrow"}, 32'(borrow),    32'(exp_borrow));
    chk({tag, ".zero"},   32'(zero),      32'(exp_zero));
    chk({tag, ".vld"},    32'(out_valid), 32'(exp_vld));
  endtask

  int sweep_exp [11] = '{5, 4, 3, 2, 1, 0, 31, 30, 29, 28, 27};

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 4'd10; b = 4'd5; a8 = '0; b8 = '0;

    // Reset held two cycles with live inputs
    tick();
    chk_out("rst1", 0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rst2", 0, 1'b0, 1'b0, 1'b0);
    chk("rst2.vld8", 32'(out_valid8), 32'd0);

    // Sweep a = 10..0 with b = 5
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      a = 4'(10 - i); b = 4'd5;
      tick();
      chk_out($sformatf("sweep_a%0d", 10 - i), sweep_exp[i],
              (10 - i) <= 4, (10 - i) == 5, 1'b1);
    end

    // Corners
    a = 4'd15; b = 4'd0;  tick(); chk_out("c15_0",  15, 1'b0, 1'b0, 1'b1);
    a = 4'd0;  b = 4'd15; tick(); chk_out("c0_15",  17, 1'b1, 1'b0, 1'b1);
    a = 4'd15; b = 4'd15; tick(); chk_out("c15_15", 0,  1'b0, 1'b1, 1'b1);

    // Single valid pulse, then hold while inputs change underneath
    a = 4'd9; b = 4'd5; tick(); chk_out("pulse", 4, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0; a = 4'd0; b = 4'd15;
    tick(); chk_out("hold1", 4, 1'b0, 1'b0, 1'b0);
    tick(); chk_out("hold2", 4, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a stream
    in_valid = 1'b1; a = 4'd12; b = 4'd3;
    tick(); chk_out("pre_rst", 9, 1'b0, 1'b0, 1'b1);
    rst = 1'b1; a = 4'd7; b = 4'd2;
    tick(); chk_out("mid_rst", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); chk_out("post_rst", 5, 1'b0, 1'b0, 1'b1);

    // Exhaustive WIDTH=4 against the package model, random WIDTH=8 alongside
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        logic [32:0] r4, r8;
        a = 4'(ia); b = 4'(ib);
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        if ((ia + ib) % 17 == 0) b8 = a8;
        r4 = ref_sub(32'(a), 32'(b), 4);
        r8 = ref_sub(32'(a8), 32'(b8), 8);
        tick();
        chk($sformatf("ex4_%0d_%0d", ia, ib), 32'(diff), r4[31:0]);
        chk($sformatf("ex4z_%0d_%0d", ia, ib), 32'(zero), 32'(ia == ib));
        chk($sformatf("ex4b_%0d_%0d", ia, ib), 32'(borrow), 32'(ia < ib));
        chk($sformatf("r8_%0d_%0d", a8, b8), 32'(diff8), r8[31:0]);
        chk($sformatf("r8b_%0d_%0d", a8, b8), 32'(borrow8), 32'(r8[8]));
        chk($sformatf("r8z_%0d_%0d", a8, b8), 32'(zero8), 32'(r8[8:0] == 9'd0));
        chk("r8vld", 32'(out_valid8), 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
